// File: rtl/sort_batch_packer_pkg.sv
// +---------------------------------------------------------------------------+
// | sort_batch_packer_pkg                                                     |
// | Shared constants and slot-range helper for the packer and bitonic sorter. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package sort_batch_packer_pkg;

    localparam int P_LOG_DEF = 4;
    localparam int DATW_DEF  = 64;
    localparam int KEYW_DEF  = 32;

    // Default-configuration batch geometry, shared with the sorter.
    localparam int                    P       = 1 << P_LOG_DEF;
    localparam int                    CNT_W   = P_LOG_DEF + 1;
    localparam logic [DATW_DEF-1:0]   PAD_REC = {DATW_DEF{1'b1}};

    // Bit offset of slot i inside a packed batch.
    function automatic int slot_base(input int datw, input int i);
        return datw * i;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort_batch_packer.sv
// +---------------------------------------------------------------------------+
// | sort_batch_packer                                                         |
// | Packs a serial record stream into padded 2^P_LOG-wide sorter batches.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module sort_batch_packer
    import sort_batch_packer_pkg::*;
#(
    parameter int P_LOG = P_LOG_DEF,
    parameter int DATW  = DATW_DEF,
    parameter int KEYW  = KEYW_DEF
) (
    input  logic                      CLK,
    input  logic                      RST_X,
    input  logic [DATW-1:0]           IDATA,
    input  logic                      IVALID,
    input  logic                      ILAST,
    output logic                      IREADY,
    input  logic                      FLUSH,
    output logic [(DATW<<P_LOG)-1:0]  DOT,
    output logic                      DOTEN,
    output logic [P_LOG:0]            DOTCNT,
    output logic                      DOTLAST
);

    localparam int                 c_P     = 1 << P_LOG;
    localparam int                 c_CNT_W = P_LOG + 1;
    localparam int                 c_DOTW  = DATW << P_LOG;
    localparam logic [DATW-1:0]    c_PAD   = {DATW{1'b1}};
    localparam logic [c_CNT_W-1:0] c_P_CNT = c_CNT_W'(c_P);

    generate
        if (KEYW > DATW || KEYW < 1) begin : g_bad_keyw
            $error("sort_batch_packer: KEYW must lie in 1..DATW");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;
    logic [DATW-1:0]    r_buf [0:c_P-1];
    logic [c_DOTW-1:0]  r_dot;
    logic               r_doten;
    logic [c_CNT_W-1:0] r_dotcnt;
    logic               r_dotlast;
    logic               r_ready;

    logic               w_accept;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_close;
    logic [DATW-1:0]    w_merged [0:c_P-1];
    logic [c_DOTW-1:0]  w_pack;

    assign w_accept   = IVALID && r_ready;
    assign w_cnt_next = r_cnt + {{(c_CNT_W-1){1'b0}}, w_accept};
    assign w_close    = (w_accept && ((w_cnt_next == c_P_CNT) || ILAST))
                      || (FLUSH && (w_cnt_next != '0));

    // The closing beat never sits in r_buf, so it is merged here on the way out.
    always_comb begin
        for (int i = 0; i < c_P; i++) begin
            w_merged[i] = r_buf[i];
        end
        if (w_accept) begin
            w_merged[r_cnt[P_LOG-1:0]] = IDATA;
        end
        w_pack = '0;
        for (int i = 0; i < c_P; i++) begin
            w_pack[slot_base(DATW, i) +: DATW] = w_merged[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_cnt     <= '0;
            r_dot     <= '0;
            r_doten   <= 1'b0;
            r_dotcnt  <= '0;
            r_dotlast <= 1'b0;
            r_ready   <= 1'b0;
            for (int i = 0; i < c_P; i++) begin
                r_buf[i] <= c_PAD;
            end
        end else begin
            r_ready <= 1'b1;
            r_doten <= w_close;
            if (w_close) begin
                r_dot     <= w_pack;
                r_dotcnt  <= w_cnt_next;
                r_dotlast <= w_accept && ILAST;
                r_cnt     <= '0;
                for (int i = 0; i < c_P; i++) begin
                    r_buf[i] <= c_PAD;
                end
            end else if (w_accept) begin
                r_buf[r_cnt[P_LOG-1:0]] <= IDATA;
                r_cnt                   <= w_cnt_next;
            end
        end
    end

    assign IREADY  = r_ready;
    assign DOT     = r_dot;
    assign DOTEN   = r_doten;
    assign DOTCNT  = r_dotcnt;
    assign DOTLAST = r_dotlast;

endmodule

`default_nettype wire

// File: tb/tb_sort_batch_packer.sv
// +---------------------------------------------------------------------------+
// | tb_sort_batch_packer                                                      |
// | Self-checking bench: queue-based batch model plus directed literal checks.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_sort_batch_packer;

    localparam int P_LOG = 4;
    localparam int DATW  = 64;
    localparam int KEYW  = 32;
    localparam int P     = 1 << P_LOG;
    localparam int PW    = DATW << P_LOG;

    logic              CLK = 1'b0;
    logic              RST_X = 1'b1;
    logic [DATW-1:0]   IDATA = '0;
    logic              IVALID = 1'b0;
    logic              ILAST = 1'b0;
    logic              IREADY;
    logic              FLUSH = 1'b0;
    logic [PW-1:0]     DOT;
    logic              DOTEN;
    logic [P_LOG:0]    DOTCNT;
    logic              DOTLAST;

    sort_batch_packer #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
        .CLK(CLK), .RST_X(RST_X), .IDATA(IDATA), .IVALID(IVALID),
        .ILAST(ILAST), .IREADY(IREADY), .FLUSH(FLUSH), .DOT(DOT),
        .DOTEN(DOTEN), .DOTCNT(DOTCNT), .DOTLAST(DOTLAST)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cyc[$];

    // Model: pending records in a queue; a batch is whatever the queue holds at close.
    logic [DATW-1:0] m_q[$];
    logic [PW-1:0]   m_dot = '0;
    logic            m_doten = 1'b0;
    int              m_cnt = 0;
    logic            m_last = 1'b0;
    logic            m_ready = 1'b0;
    bit              m_acc;
    bit              m_close;

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            m_q.delete();
            m_dot = '0; m_doten = 1'b0; m_cnt = 0; m_last = 1'b0; m_ready = 1'b0;
        end else begin
            m_acc = m_ready && IVALID;
            if (m_acc) m_q.push_back(IDATA);
            m_close = (m_acc && (m_q.size() == P || ILAST)) || (FLUSH && m_q.size() > 0);
            m_doten = m_close;
            if (m_close) begin
                m_dot = '1;
                foreach (m_q[k]) m_dot[k*DATW +: DATW] = m_q[k];
                m_cnt  = m_q.size();
                m_last = m_acc && ILAST;
                m_q.delete();
            end
            m_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dot(input string name, input logic [PW-1:0] exp);
        n_chk++;
        if (DOT !== exp) begin
            n_err++;
            for (int s = 0; s < P; s++) begin
                if (DOT[s*DATW +: DATW] !== exp[s*DATW +: DATW]) begin
                    $display("FAIL %s slot %0d: got %0h expected %0h (t=%0t)", name, s,
                             DOT[s*DATW +: DATW], exp[s*DATW +: DATW], $time);
                    break;
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        chk("ready", 64'(IREADY), 64'(m_ready));
        chk("doten", 64'(DOTEN), 64'(m_doten));
        chk("dotcnt", 64'(DOTCNT), 64'(m_cnt));
        chk("dotlast", 64'(DOTLAST), 64'(m_last));
        chk_dot("dot", m_dot);
        if (DOTEN === 1'b1) pulse_cyc.push_back(cyc);
    end

    function automatic logic [63:0] rec(input int key);
        return {32'hC0DE_0000 | 32'(key), 32'(key)};
    endfunction

    task automatic drive(input bit v, input logic [63:0] d, input bit l, input bit f);
        IVALID = v; IDATA = d; ILAST = l; FLUSH = f;
        @(negedge CLK); #1;
        IVALID = 1'b0; ILAST = 1'b0; FLUSH = 1'b0;
    endtask

    int n0;

    initial begin
        #1 RST_X = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST_X = 1'b1;
        chk("rst_ready", 64'(IREADY), 64'd0);
        chk("rst_dotcnt", 64'(DOTCNT), 64'd0);
        drive(0, '0, 0, 0);
        chk("ready_up", 64'(IREADY), 64'd1);

        // Keys 15..0, full batch.
        n0 = pulse_cyc.size();
        for (int i = 0; i < P; i++) begin
            drive(1, rec(15 - i), 0, 0);
            if (i < P - 1) chk("full_no_early_en", 64'(DOTEN), 64'd0);
        end
        chk("full_en", 64'(DOTEN), 64'd1);
        chk("full_cnt", 64'(DOTCNT), 64'd16);
        chk("full_last", 64'(DOTLAST), 64'd0);
        for (int i = 0; i < P; i++) chk("full_key", 64'(DOT[i*DATW +: KEYW]), 64'(15 - i));
        drive(0, '0, 0, 0);
        chk("full_en_drop", 64'(DOTEN), 64'd0);
        chk("full_one_pulse", 64'(pulse_cyc.size() - n0), 64'd1);

        // Five beats closed by ILAST.
        for (int i = 0; i < 5; i++) drive(1, rec(10 + i), i == 4, 0);
        chk("last_cnt", 64'(DOTCNT), 64'd5);
        chk("last_flag", 64'(DOTLAST), 64'd1);
        for (int i = 0; i < 5; i++) chk("last_key", 64'(DOT[i*DATW +: KEYW]), 64'(10 + i));
        for (int i = 5; i < P; i++) chk("last_pad", DOT[i*DATW +: DATW], 64'hFFFF_FFFF_FFFF_FFFF);

        // Empty flush, then three beats and a separate flush.
        n0 = pulse_cyc.size();
        drive(0, '0, 0, 1);
        drive(0, '0, 0, 0);
        chk("eflush_en", 64'(pulse_cyc.size() - n0), 64'd0);
        chk("eflush_cnt", 64'(DOTCNT), 64'd5);
        for (int i = 0; i < 3; i++) drive(1, rec(40 + i), 0, 0);
        drive(0, '0, 0, 1);
        chk("flush_en", 64'(DOTEN), 64'd1);
        chk("flush_cnt", 64'(DOTCNT), 64'd3);
        chk("flush_last", 64'(DOTLAST), 64'd0);
        chk("flush_pad3", DOT[3*DATW +: DATW], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_key2", 64'(DOT[2*DATW +: KEYW]), 64'd42);

        // Reset mid-fill.
        for (int i = 0; i < 7; i++) drive(1, rec(60 + i), 0, 0);
        n0 = pulse_cyc.size();
        RST_X = 1'b0;
        #1;
        n_chk++;
        if (DOT !== '0) begin
            n_err++;
            $display("FAIL midrst_dot: got nonzero %0h expected 0", DOT[63:0]);
        end
        chk("midrst_cnt", 64'(DOTCNT), 64'd0);
        chk("midrst_ready", 64'(IREADY), 64'd0);
        chk("midrst_en", 64'(DOTEN), 64'd0);
        repeat (2) @(negedge CLK);
        #1 RST_X = 1'b1;
        drive(0, '0, 0, 0);
        for (int i = 0; i < P; i++) drive(1, rec(100 + i), 0, 0);
        chk("postrst_pulses", 64'(pulse_cyc.size() - n0), 64'd1);
        chk("postrst_key0", 64'(DOT[0 +: KEYW]), 64'd100);
        chk("postrst_key15", 64'(DOT[15*DATW +: KEYW]), 64'd115);

        // ILAST on the P-th beat.
        for (int i = 0; i < P; i++) drive(1, rec(200 + i), i == P - 1, 0);
        chk("plast_cnt", 64'(DOTCNT), 64'd16);
        chk("plast_flag", 64'(DOTLAST), 64'd1);

        // 48 back-to-back beats.
        n0 = pulse_cyc.size();
        for (int i = 0; i < 48; i++) drive(1, rec(300 + i), 0, 0);
        drive(0, '0, 0, 0);
        chk("stream_pulses", 64'(pulse_cyc.size() - n0), 64'd3);
        if (pulse_cyc.size() - n0 == 3) begin
            chk("stream_gap1", 64'(pulse_cyc[n0+1] - pulse_cyc[n0]), 64'd16);
            chk("stream_gap2", 64'(pulse_cyc[n0+2] - pulse_cyc[n0+1]), 64'd16);
        end
        chk("stream_key", 64'(DOT[5*DATW +: KEYW]), 64'd337);

        // FLUSH together with the 16th beat.
        n0 = pulse_cyc.size();
        for (int i = 0; i < P; i++) drive(1, rec(500 + i), 0, i == P - 1);
        chk("fp_cnt", 64'(DOTCNT), 64'd16);
        repeat (4) drive(0, '0, 0, 0);
        chk("fp_pulses", 64'(pulse_cyc.size() - n0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
